// File: rtl/multicycle_ctrl.sv
// Main controller for the multicycle MIPS-style datapath: Moore FSM whose outputs
// decode the current state, plus mem_ready in the memory states.
module multicycle_ctrl #(
  parameter int unsigned OPW             = 6,
  parameter bit          MEM_WAIT        = 1'b1,
  parameter bit          TRAP_ON_ILLEGAL = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] opcode,
  input  logic           mem_ready,
  output logic           mem_req,
  output logic           mem_we,
  output logic           iord,
  output logic           ir_write,
  output logic           pc_write,
  output logic           reg_write,
  output logic           branch,
  output logic           branch_ne,
  output logic           reg_dst,
  output logic           mem_to_reg,
  output logic           imm_zext,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     alu_op,
  output logic [1:0]     pc_src,
  output logic           illegal,
  output logic           retire
);

  localparam logic [OPW-1:0] OP_R    = OPW'('h00);
  localparam logic [OPW-1:0] OP_LW   = OPW'('h23);
  localparam logic [OPW-1:0] OP_SW   = OPW'('h2B);
  localparam logic [OPW-1:0] OP_ADDI = OPW'('h08);
  localparam logic [OPW-1:0] OP_ORI  = OPW'('h0D);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'('h04);
  localparam logic [OPW-1:0] OP_BNE  = OPW'('h05);
  localparam logic [OPW-1:0] OP_J    = OPW'('h02);

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC, ALUWB, MEMADR, MEMRD, MEMWB, MEMWR,
    IEXEC, IWB, BRANCH, JUMP, ILLEGAL, HALT
  } state_e;

  state_e state_q, state_d;
  logic   rdy;

  assign rdy = MEM_WAIT ? mem_ready : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (rdy) state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_R:            state_d = EXEC;
          OP_LW, OP_SW:    state_d = MEMADR;
          OP_ADDI, OP_ORI: state_d = IEXEC;
          OP_BEQ, OP_BNE:  state_d = BRANCH;
          OP_J:            state_d = JUMP;
          default:         state_d = ILLEGAL;
        endcase
      end
      EXEC:    state_d = ALUWB;
      MEMADR:  state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   if (rdy) state_d = MEMWB;
      MEMWR:   if (rdy) state_d = FETCH;
      IEXEC:   state_d = IWB;
      ILLEGAL: state_d = TRAP_ON_ILLEGAL ? HALT : FETCH;
      HALT:    state_d = HALT;
      ALUWB, MEMWB, IWB, BRANCH, JUMP: state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Outputs are forced low while rst_n is low so no write can leak through reset.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    branch     = 1'b0;
    branch_ne  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    imm_zext   = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    illegal    = 1'b0;
    retire     = 1'b0;
    if (rst_n) begin
      case (state_q)
        FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = rdy;
          pc_write  = rdy;
        end
        DECODE:  alu_src_b = 2'b11;
        EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        ALUWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          retire    = 1'b1;
        end
        MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          retire     = 1'b1;
        end
        MEMWR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
          retire  = rdy;
        end
        IEXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          imm_zext  = (opcode == OP_ORI);
          alu_op    = (opcode == OP_ORI) ? 2'b11 : 2'b00;
        end
        IWB: begin
          reg_write = 1'b1;
          imm_zext  = (opcode == OP_ORI);
          retire    = 1'b1;
        end
        BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b01;
          pc_src    = 2'b01;
          branch    = (opcode == OP_BEQ);
          branch_ne = (opcode == OP_BNE);
          retire    = 1'b1;
        end
        JUMP: begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
          retire   = 1'b1;
        end
        ILLEGAL, HALT: illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: three instances (default, trapping, no-wait)
// share stimulus; each cycle's expected outputs are queued and checked at negedge.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic mem_req, mem_we, iord, ir_write, pc_write, reg_write;
    logic branch, branch_ne, reg_dst, mem_to_reg, imm_zext, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic illegal, retire;
  } out_t;

  typedef enum {
    S_RST, S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_MEMADR, S_MEMRD, S_MEMWB,
    S_MEMWR, S_IEXEC, S_IWB, S_BRANCH, S_JUMP, S_ILLEGAL, S_HALT
  } tst_e;

  typedef struct {
    int    sel;
    out_t  exp;
    string name;
  } item_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic       mem_ready = 1'b1;
  out_t       ov [3];
  item_t      sb [$];
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic mem_req, mem_we, iord, ir_write, pc_write, reg_write;
    logic branch, branch_ne, reg_dst, mem_to_reg, imm_zext, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic illegal, retire;

    multicycle_ctrl #(
      .OPW(6),
      .MEM_WAIT(g != 2),
      .TRAP_ON_ILLEGAL(g == 1)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
      .pc_write(pc_write), .reg_write(reg_write), .branch(branch),
      .branch_ne(branch_ne), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .imm_zext(imm_zext), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .pc_src(pc_src), .illegal(illegal), .retire(retire)
    );

    assign ov[g] = {mem_req, mem_we, iord, ir_write, pc_write, reg_write,
                    branch, branch_ne, reg_dst, mem_to_reg, imm_zext, alu_src_a,
                    alu_src_b, alu_op, pc_src, illegal, retire};
  end

  // Expected outputs per state, straight from the controller's output table.
  function automatic out_t exp_vec(input tst_e st, input logic [5:0] op, input logic rdy);
    out_t e;
    e = '0;
    case (st)
      S_FETCH:   begin e.mem_req = 1; e.alu_src_b = 2'b01; e.ir_write = rdy; e.pc_write = rdy; end
      S_DECODE:  e.alu_src_b = 2'b11;
      S_EXEC:    begin e.alu_src_a = 1; e.alu_op = 2'b10; end
      S_ALUWB:   begin e.reg_write = 1; e.reg_dst = 1; e.retire = 1; end
      S_MEMADR:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      S_MEMRD:   begin e.mem_req = 1; e.iord = 1; end
      S_MEMWB:   begin e.reg_write = 1; e.mem_to_reg = 1; e.retire = 1; end
      S_MEMWR:   begin e.mem_req = 1; e.mem_we = 1; e.iord = 1; e.retire = rdy; end
      S_IEXEC:   begin
        e.alu_src_a = 1; e.alu_src_b = 2'b10;
        e.imm_zext = (op == 6'h0D); e.alu_op = (op == 6'h0D) ? 2'b11 : 2'b00;
      end
      S_IWB:     begin e.reg_write = 1; e.imm_zext = (op == 6'h0D); e.retire = 1; end
      S_BRANCH:  begin
        e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_src = 2'b01; e.retire = 1;
        e.branch = (op == 6'h04); e.branch_ne = (op == 6'h05);
      end
      S_JUMP:    begin e.pc_write = 1; e.pc_src = 2'b10; e.retire = 1; end
      S_ILLEGAL, S_HALT: e.illegal = 1;
      default: ;
    endcase
    return e;
  endfunction

  // One cycle: inputs change just after the edge, the expected response is queued.
  task automatic step(input string nm, input tst_e st, input logic [5:0] op,
                      input logic mr, input int sel);
    logic eff;
    @(posedge clk);
    #1;
    opcode    = op;
    mem_ready = mr;
    rst_n     = (st != S_RST);
    eff       = (sel == 2) ? 1'b1 : mr;
    sb.push_back('{sel: sel, exp: exp_vec(st, op, eff), name: nm});
  endtask

  // rst_n pulsed low inside a single cycle, never spanning a rising edge.
  task automatic rst_pulse_mid(input string nm, input int sel);
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    sb.push_back('{sel: sel, exp: '0, name: nm});
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    item_t it;
    out_t  got;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        it  = sb.pop_front();
        got = ov[it.sel];
        checks++;
        if (got !== it.exp) begin
          failures++;
          $display("FAIL %s dut%0d: got %h expected %h", it.name, it.sel, got, it.exp);
        end
      end
    end
  end

  initial begin : stimulus
    for (int unsigned i = 0; i < 3; i++) step("reset", S_RST, 6'h00, 1'b1, 0);

    step("r_fetch", S_FETCH, 6'h00, 1'b1, 0);
    step("r_decode", S_DECODE, 6'h00, 1'b1, 0);
    step("r_exec", S_EXEC, 6'h00, 1'b1, 0);
    step("r_aluwb", S_ALUWB, 6'h00, 1'b1, 0);

    step("lw_fetch_wait", S_FETCH, 6'h23, 1'b0, 0);
    step("lw_fetch_wait", S_FETCH, 6'h23, 1'b0, 0);
    step("lw_fetch", S_FETCH, 6'h23, 1'b1, 0);
    step("lw_decode", S_DECODE, 6'h23, 1'b1, 0);
    step("lw_memadr", S_MEMADR, 6'h23, 1'b1, 0);
    for (int unsigned i = 0; i < 3; i++) step("lw_memrd_wait", S_MEMRD, 6'h23, 1'b0, 0);
    step("lw_memrd", S_MEMRD, 6'h23, 1'b1, 0);
    step("lw_memwb", S_MEMWB, 6'h23, 1'b1, 0);

    step("sw_fetch", S_FETCH, 6'h2B, 1'b1, 0);
    step("sw_decode", S_DECODE, 6'h2B, 1'b1, 0);
    step("sw_memadr", S_MEMADR, 6'h2B, 1'b1, 0);
    step("sw_memwr", S_MEMWR, 6'h2B, 1'b1, 0);

    step("ori_fetch", S_FETCH, 6'h0D, 1'b1, 0);
    step("ori_decode", S_DECODE, 6'h0D, 1'b1, 0);
    step("ori_iexec", S_IEXEC, 6'h0D, 1'b1, 0);
    step("ori_iwb", S_IWB, 6'h0D, 1'b1, 0);

    step("addi_fetch", S_FETCH, 6'h08, 1'b1, 0);
    step("addi_decode", S_DECODE, 6'h08, 1'b1, 0);
    step("addi_iexec", S_IEXEC, 6'h08, 1'b1, 0);
    step("addi_iwb", S_IWB, 6'h08, 1'b1, 0);

    step("bne_fetch", S_FETCH, 6'h05, 1'b1, 0);
    step("bne_decode", S_DECODE, 6'h05, 1'b1, 0);
    step("bne_branch", S_BRANCH, 6'h05, 1'b1, 0);

    step("j_fetch", S_FETCH, 6'h02, 1'b1, 0);
    step("j_decode", S_DECODE, 6'h02, 1'b1, 0);
    step("j_jump", S_JUMP, 6'h02, 1'b1, 0);

    step("beq_fetch", S_FETCH, 6'h04, 1'b1, 0);
    step("beq_decode", S_DECODE, 6'h04, 1'b1, 0);
    step("beq_branch", S_BRANCH, 6'h04, 1'b1, 0);

    step("ill_fetch", S_FETCH, 6'h3F, 1'b1, 0);
    step("ill_decode", S_DECODE, 6'h3F, 1'b1, 0);
    step("ill_flag", S_ILLEGAL, 6'h3F, 1'b1, 0);
    step("ill_refetch", S_FETCH, 6'h00, 1'b1, 0);

    for (int unsigned i = 0; i < 22; i++) step("trap_halt", S_HALT, 6'h00, 1'b1, 1);
    step("trap_reset", S_RST, 6'h00, 1'b1, 1);
    step("trap_reset", S_RST, 6'h00, 1'b1, 1);
    step("trap_fetch", S_FETCH, 6'h2B, 1'b1, 1);

    step("swr_decode", S_DECODE, 6'h2B, 1'b1, 0);
    step("swr_memadr", S_MEMADR, 6'h2B, 1'b1, 0);
    step("swr_memwr_wait", S_MEMWR, 6'h2B, 1'b0, 0);
    step("swr_memwr_wait", S_MEMWR, 6'h2B, 1'b0, 0);
    rst_pulse_mid("swr_async_reset", 0);
    step("swr_fetch_after", S_FETCH, 6'h00, 1'b0, 0);
    step("swr_fetch", S_FETCH, 6'h00, 1'b1, 0);
    step("swr_r_decode", S_DECODE, 6'h00, 1'b1, 0);
    step("swr_r_exec", S_EXEC, 6'h00, 1'b1, 0);
    step("swr_r_aluwb", S_ALUWB, 6'h00, 1'b1, 0);

    step("nw_reset", S_RST, 6'h23, 1'b0, 2);
    step("nw_fetch", S_FETCH, 6'h23, 1'b0, 2);
    step("nw_decode", S_DECODE, 6'h23, 1'b0, 2);
    step("nw_memadr", S_MEMADR, 6'h23, 1'b0, 2);
    step("nw_memrd", S_MEMRD, 6'h23, 1'b0, 2);
    step("nw_memwb", S_MEMWB, 6'h23, 1'b0, 2);
    step("nw_fetch_next", S_FETCH, 6'h23, 1'b0, 2);

    for (int unsigned i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
